// File: rtl/cc_cond_unit_if.sv
// ALU-to-condition-unit bus: ALU result/flags, pipeline controls, condition request
// and the registered condition-code outputs.
interface cc_cond_unit_if #(
    parameter int unsigned WIDTH = 64
);
    logic             alu_valid;
    logic             set_cc;
    logic             stall;
    logic             bubble;
    logic [WIDTH-1:0] alu_out;
    logic             alu_of;
    logic             cond_req;
    logic [3:0]       ifun;
    logic [2:0]       cc;
    logic             cnd;
    logic             cnd_valid;
    logic             cnd_illegal;
    logic [15:0]      cc_updates;

    modport master (
        output alu_valid, set_cc, stall, bubble, alu_out, alu_of, cond_req, ifun,
        input  cc, cnd, cnd_valid, cnd_illegal, cc_updates
    );

    modport slave (
        input  alu_valid, set_cc, stall, bubble, alu_out, alu_of, cond_req, ifun,
        output cc, cnd, cnd_valid, cnd_illegal, cc_updates
    );
endinterface

// File: rtl/cc_cond_unit.sv
// Y86-64 condition-code register and jXX/cmovXX condition evaluator, fed by the
// execute-stage ALU; honours stall (hold everything) and bubble (squash).
module cc_cond_unit #(
    parameter int unsigned WIDTH    = 64,
    parameter logic [2:0]  RESET_CC = 3'b100
) (
    input logic           clk,
    input logic           rst,
    cc_cond_unit_if.slave bus
);
    logic [2:0]  cc_q, cc_d;
    logic        cnd_q, cnd_d;
    logic        cnd_valid_q;
    logic        cnd_illegal_q, cnd_illegal_d;
    logic [15:0] cc_updates_q, cc_updates_d;
    logic        upd, req, zf, sf, of, lt;

    assign upd = bus.alu_valid & bus.set_cc & ~bus.stall & ~bus.bubble;
    assign req = bus.cond_req & ~bus.stall & ~bus.bubble;

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];
    assign lt = sf ^ of;

    always_comb begin
        cc_d = cc_q;
        if (upd) begin
            cc_d = {(bus.alu_out == '0), bus.alu_out[WIDTH-1], bus.alu_of};
        end
        cc_updates_d = cc_updates_q;
        if (upd && (cc_updates_q != '1)) begin
            cc_updates_d = cc_updates_q + 16'd1;
        end
    end

    // Evaluated against cc_q so a same-cycle update cannot affect the result.
    always_comb begin
        cnd_d         = 1'b0;
        cnd_illegal_d = 1'b0;
        case (bus.ifun)
            4'd0:    cnd_d = 1'b1;
            4'd1:    cnd_d = lt | zf;
            4'd2:    cnd_d = lt;
            4'd3:    cnd_d = zf;
            4'd4:    cnd_d = ~zf;
            4'd5:    cnd_d = ~lt;
            4'd6:    cnd_d = ~lt & ~zf;
            default: cnd_illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q          <= RESET_CC;
            cnd_q         <= 1'b0;
            cnd_valid_q   <= 1'b0;
            cnd_illegal_q <= 1'b0;
            cc_updates_q  <= '0;
        end else if (!bus.stall) begin
            cc_q         <= cc_d;
            cnd_valid_q  <= req;
            cc_updates_q <= cc_updates_d;
            if (req) begin
                cnd_q         <= cnd_d;
                cnd_illegal_q <= cnd_illegal_d;
            end
        end
    end

    assign bus.cc          = cc_q;
    assign bus.cnd         = cnd_q;
    assign bus.cnd_valid   = cnd_valid_q;
    assign bus.cnd_illegal = cnd_illegal_q;
    assign bus.cc_updates  = cc_updates_q;
endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed checks of cc_cond_unit: reset, flag capture, condition codes,
// stall/bubble, illegal codes and update-counter saturation.
module tb_cc_cond_unit;
    logic clk;
    logic rst;
    int unsigned n_chk;
    int unsigned n_pass;
    int unsigned cnt_m;

    cc_cond_unit_if #(.WIDTH(64)) bus ();

    cc_cond_unit #(.WIDTH(64), .RESET_CC(3'b100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; the counter model tracks accepted updates independently.
    task automatic step();
        if (!rst && bus.alu_valid && bus.set_cc && !bus.stall && !bus.bubble && cnt_m < 65535) begin
            cnt_m++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.set_cc    = 1'b0;
        bus.stall     = 1'b0;
        bus.bubble    = 1'b0;
        bus.alu_out   = '0;
        bus.alu_of    = 1'b0;
        bus.cond_req  = 1'b0;
        bus.ifun      = 4'd0;
    endtask

    task automatic alu(input logic [63:0] val, input logic ovf);
        bus.alu_valid = 1'b1;
        bus.set_cc    = 1'b1;
        bus.alu_out   = val;
        bus.alu_of    = ovf;
    endtask

    task automatic req(input logic [3:0] f);
        bus.cond_req = 1'b1;
        bus.ifun     = f;
    endtask

    initial begin
        logic [63:0] v;
        logic        o;
        n_chk  = 0;
        n_pass = 0;
        cnt_m  = 0;
        rst    = 1'b1;
        idle();
        repeat (2) step();
        chk("rst_cc", 64'(bus.cc), 64'h4);
        chk("rst_valid", 64'(bus.cnd_valid), 64'h0);
        chk("rst_cnt", 64'(bus.cc_updates), 64'h0);

        // Build some state, then reset mid-cycle with a request still driven
        rst = 1'b0;
        alu(64'd5, 1'b0);
        req(4'd3);
        step();
        chk("pre_rst_cc", 64'(bus.cc), 64'h0);
        chk("pre_rst_cnd", 64'(bus.cnd), 64'h1);
        chk("pre_rst_valid", 64'(bus.cnd_valid), 64'h1);
        #3 rst = 1'b1;
        cnt_m = 0;
        #1;
        chk("async_rst_cc", 64'(bus.cc), 64'h4);
        chk("async_rst_valid", 64'(bus.cnd_valid), 64'h0);
        chk("async_rst_cnt", 64'(bus.cc_updates), 64'h0);
        idle();
        rst = 1'b0;
        step();
        chk("post_rst_no_pulse", 64'(bus.cnd_valid), 64'h0);
        req(4'd3);
        step();
        chk("post_rst_e_cnd", 64'(bus.cnd), 64'h1);
        chk("post_rst_e_valid", 64'(bus.cnd_valid), 64'h1);

        // Overflowing subtraction result
        idle();
        alu(64'h8000000000000001, 1'b1);
        step();
        chk("ovf_cc", 64'(bus.cc), 64'h3);
        chk("ovf_cnt", 64'(bus.cc_updates), 64'h1);
        idle();
        req(4'd2);
        step();
        chk("ovf_l", 64'(bus.cnd), 64'h0);
        req(4'd5);
        step();
        chk("ovf_ge", 64'(bus.cnd), 64'h1);
        chk("ovf_b2b_valid", 64'(bus.cnd_valid), 64'h1);
        req(4'd1);
        step();
        chk("ovf_le", 64'(bus.cnd), 64'h0);
        req(4'd6);
        step();
        chk("ovf_g", 64'(bus.cnd), 64'h1);
        req(4'd4);
        step();
        chk("ovf_ne", 64'(bus.cnd), 64'h1);

        // Negative result without overflow: SF=1 so lt=1
        idle();
        alu(64'hFFFFFFFFFFFFFFFF, 1'b0);
        step();
        chk("neg_cc", 64'(bus.cc), 64'h2);
        idle();
        req(4'd2);
        step();
        chk("neg_l", 64'(bus.cnd), 64'h1);
        req(4'd6);
        step();
        chk("neg_g", 64'(bus.cnd), 64'h0);

        // Same-cycle update and request: condition sees the old cc
        idle();
        alu(64'd0, 1'b0);
        step();
        chk("zero_cc", 64'(bus.cc), 64'h4);
        alu(64'd5, 1'b0);
        req(4'd3);
        step();
        chk("same_cyc_cnd", 64'(bus.cnd), 64'h1);
        chk("same_cyc_cc", 64'(bus.cc), 64'h0);
        idle();
        req(4'd3);
        step();
        chk("after_upd_e", 64'(bus.cnd), 64'h0);

        // Bubble squashes update and request
        idle();
        bus.bubble = 1'b1;
        alu(64'd0, 1'b0);
        req(4'd0);
        step();
        chk("bubble_cc", 64'(bus.cc), 64'h0);
        chk("bubble_cnt", 64'(bus.cc_updates), 64'(cnt_m));
        chk("bubble_valid", 64'(bus.cnd_valid), 64'h0);

        // Stall holds a pulse and blocks updates
        idle();
        req(4'd0);
        step();
        chk("stall_pre_valid", 64'(bus.cnd_valid), 64'h1);
        idle();
        bus.stall = 1'b1;
        bus.bubble = 1'b1;
        alu(64'd0, 1'b1);
        step();
        chk("stall_hold_valid1", 64'(bus.cnd_valid), 64'h1);
        step();
        chk("stall_hold_valid2", 64'(bus.cnd_valid), 64'h1);
        chk("stall_cc", 64'(bus.cc), 64'h0);
        chk("stall_cnt", 64'(bus.cc_updates), 64'(cnt_m));
        idle();
        step();
        chk("stall_release_valid", 64'(bus.cnd_valid), 64'h0);

        // Illegal code, then hold of cnd/cnd_illegal between pulses
        req(4'd9);
        step();
        chk("ill_cnd", 64'(bus.cnd), 64'h0);
        chk("ill_flag", 64'(bus.cnd_illegal), 64'h1);
        chk("ill_valid", 64'(bus.cnd_valid), 64'h1);
        idle();
        bus.set_cc = 1'b1;
        bus.alu_out = 64'd0;
        step();
        chk("ill_pulse_end", 64'(bus.cnd_valid), 64'h0);
        chk("ill_flag_hold", 64'(bus.cnd_illegal), 64'h1);
        chk("noval_cc_hold", 64'(bus.cc), 64'h0);
        idle();
        req(4'd0);
        step();
        chk("always_cnd", 64'(bus.cnd), 64'h1);
        chk("always_ill", 64'(bus.cnd_illegal), 64'h0);

        // Counter saturation with random results checked against flag model
        idle();
        for (int i = 0; i < 65540; i++) begin
            v = {$urandom, $urandom};
            if (i % 7 == 0) v = '0;
            o = 1'($urandom_range(1));
            alu(v, o);
            step();
            if (bus.cc !== {(v == 64'd0), v[63], o}) begin
                chk("rand_cc", 64'(bus.cc), 64'({(v == 64'd0), v[63], o}));
            end else begin
                n_chk++;
                n_pass++;
            end
        end
        chk("sat_cnt_model", 64'(bus.cc_updates), 64'(cnt_m));
        chk("sat_cnt", 64'(bus.cc_updates), 64'hFFFF);
        alu(64'd1, 1'b0);
        repeat (3) step();
        chk("sat_hold", 64'(bus.cc_updates), 64'hFFFF);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
